// File: rtl/spm_pkg.sv
// Shared types and constants for the serial-parallel multiplier (spm) and its controller.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } spm_state_e;

  localparam int SPM_WIDTH = 32;
  localparam int SPM_PLAT  = 1;

  // Number of RUN cycles: 2*w product bits plus the spm pipeline latency.
  function automatic int spm_cycles(input int w, input int plat);
    return 2 * w + plat;
  endfunction

endpackage

// File: rtl/spm_serdes_ctrl.sv
// Operand serializer / product deserializer driving one signed serial-parallel multiplier.
// Multiplicand is held on spm_x, multiplier is shifted out LSB first, product bits are shifted in.
module spm_serdes_ctrl
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH,
  parameter int PLAT  = SPM_PLAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mc,
  input  logic [WIDTH-1:0]   mp,
  output logic [WIDTH-1:0]   spm_x,
  output logic               spm_y,
  input  logic               spm_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
);

  localparam int NCYC = spm_cycles(WIDTH, PLAT);
  localparam int CW   = $clog2(NCYC + 1);

  localparam logic [CW-1:0] LAST_K  = CW'(NCYC - 1);
  localparam logic [CW-1:0] PLAT_K  = CW'(PLAT);
  localparam logic [CW-1:0] WIDTH_K = CW'(WIDTH);
  localparam logic [CW-1:0] DBL_K   = CW'(2 * WIDTH);

  spm_state_e           state_q, state_d;
  logic [CW-1:0]        k_q, k_d;
  logic [WIDTH-1:0]     spm_x_q, spm_x_d;
  logic [WIDTH-1:0]     mp_q, mp_d;
  logic                 spm_y_q, spm_y_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  // Serial multiplier bit for step k: raw bits, then sign extension, then zero flush.
  function automatic logic y_bit(input logic [CW-1:0] k, input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] sh;
    sh = m >> k;
    if (k < WIDTH_K) begin
      return sh[0];
    end else if (k < DBL_K) begin
      return m[WIDTH-1];
    end else begin
      return 1'b0;
    end
  endfunction

  // spm_y is loaded with the bit for the next k so that it is on the wire during cycle k.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    spm_x_d = spm_x_q;
    mp_d    = mp_q;
    spm_y_d = 1'b0;
    prod_d  = prod_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          k_d     = '0;
          spm_x_d = mc;
          mp_d    = mp;
          spm_y_d = mp[0];
        end
      end

      RUN: begin
        if (k_q >= PLAT_K) begin
          prod_d = {spm_p, prod_q[2*WIDTH-1:1]};
        end
        if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + CW'(1);
          spm_y_d = y_bit(k_q + CW'(1), mp_q);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      spm_x_q <= '0;
      mp_q    <= '0;
      spm_y_q <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      spm_x_q <= spm_x_d;
      mp_q    <= mp_d;
      spm_y_q <= spm_y_d;
      prod_q  <= prod_d;
    end
  end

  // Handshake flags decode registered state only, so neither handshake loops through.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign spm_x     = spm_x_q;
  assign spm_y     = spm_y_q;
  assign prod      = prod_q;

endmodule

// File: tb/tb_spm_serdes_ctrl.sv
// Self-checking bench: two controllers (PLAT=1 and PLAT=3), each paired with a behavioural spm model.
module tb_spm_serdes_ctrl;
  import spm_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  logic           in_valid_a  [2];
  logic [W-1:0]   mc_a        [2];
  logic [W-1:0]   mp_a        [2];
  logic           out_ready_a [2];
  wire            in_ready_a  [2];
  wire  [W-1:0]   spm_x_a     [2];
  wire            spm_y_a     [2];
  wire            spm_p_a     [2];
  wire            out_valid_a [2];
  wire  [2*W-1:0] prod_a      [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int PL = (g == 0) ? 1 : 3;

    spm_serdes_ctrl #(.WIDTH(W), .PLAT(PL)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid_a[g]),
      .in_ready (in_ready_a[g]),
      .mc       (mc_a[g]),
      .mp       (mp_a[g]),
      .spm_x    (spm_x_a[g]),
      .spm_y    (spm_y_a[g]),
      .spm_p    (spm_p_a[g]),
      .out_valid(out_valid_a[g]),
      .out_ready(out_ready_a[g]),
      .prod     (prod_a[g])
    );

    // Behavioural spm: accumulates x*y bit by bit, emits product bit j PL cycles after y bit j.
    logic [2*W-1:0] acc;
    logic [2*W-1:0] nacc;
    int             cnt;
    logic [3:0]     pipe;
    logic           pbit;

    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        acc  <= '0;
        cnt  <= 0;
        pipe <= '0;
      end else if (in_valid_a[g] && in_ready_a[g]) begin
        acc  <= '0;
        cnt  <= 0;
        pipe <= {pipe[2:0], 1'b0};
      end else begin
        nacc = acc;
        pbit = 1'b0;
        if (cnt < 2 * W) begin
          if (spm_y_a[g]) begin
            nacc = acc + ({{W{spm_x_a[g][W-1]}}, spm_x_a[g]} << cnt);
          end
          pbit = nacc[cnt];
        end
        acc  <= nacc;
        cnt  <= cnt + 1;
        pipe <= {pipe[2:0], pbit};
      end
    end

    assign spm_p_a[g] = pipe[PL-1];
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    int             stall;
    logic           pre;
  } vec_t;

  vec_t vecs [6];

  function automatic int lanePlat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transaction: handshake, RUN, optional back-pressure, product handshake.
  task automatic applyStimulus(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] expP, input int stall, input logic pre,
                               input string name);
    int             lat;
    logic           xStable;
    logic           held;
    logic [2*W-1:0] p;

    @(negedge clk);
    checkOutput({name, " in_ready idle"}, 64'(in_ready_a[d]), 64'd1);
    mc_a[d]        = a;
    mp_a[d]        = b;
    in_valid_a[d]  = 1'b1;
    out_ready_a[d] = pre;
    @(posedge clk);
    #1;
    in_valid_a[d] = 1'b0;
    mc_a[d]       = ~a;
    mp_a[d]       = ~b;
    checkOutput({name, " in_ready drop"}, 64'(in_ready_a[d]), 64'd0);

    lat     = 0;
    xStable = 1'b1;
    while (!out_valid_a[d] && lat < 200) begin
      if (spm_x_a[d] !== a) xStable = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, " latency"}, 64'(lat), 64'(spm_cycles(W, lanePlat(d))));
    checkOutput({name, " spm_x stable"}, 64'(xStable), 64'd1);
    checkOutput({name, " prod"}, 64'(prod_a[d]), 64'(expP));

    p              = prod_a[d];
    held           = 1'b1;
    out_ready_a[d] = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid_a[d] = i[0];
      mc_a[d]       = W'($urandom);
      mp_a[d]       = W'($urandom);
      @(posedge clk);
      #1;
      if (!out_valid_a[d] || prod_a[d] !== p || in_ready_a[d] || spm_y_a[d] || spm_x_a[d] !== a)
        held = 1'b0;
    end
    if (stall > 0) checkOutput({name, " hold"}, 64'(held), 64'd1);

    in_valid_a[d]  = 1'b0;
    out_ready_a[d] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({name, " out_valid fall"}, 64'(out_valid_a[d]), 64'd0);
    checkOutput({name, " in_ready back"}, 64'(in_ready_a[d]), 64'd1);
    out_ready_a[d] = 1'b0;
  endtask

  initial begin
    logic [W-1:0]          ra;
    logic [W-1:0]          rb;
    logic signed [2*W-1:0] re;

    vecs[0] = '{a: 8'h03, b: 8'h05, p: 16'h000F, stall: 0,  pre: 1'b1};
    vecs[1] = '{a: 8'hFD, b: 8'h05, p: 16'hFFF1, stall: 0,  pre: 1'b1};
    vecs[2] = '{a: 8'h05, b: 8'hFD, p: 16'hFFF1, stall: 2,  pre: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h80, p: 16'h4000, stall: 0,  pre: 1'b0};
    vecs[4] = '{a: 8'h7F, b: 8'hFF, p: 16'hFF81, stall: 1,  pre: 1'b1};
    vecs[5] = '{a: 8'h03, b: 8'h05, p: 16'h000F, stall: 10, pre: 1'b0};

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid_a[d]  = 1'b0;
      mc_a[d]        = '0;
      mp_a[d]        = '0;
      out_ready_a[d] = 1'b0;
    end
    #2;
    checkOutput("reset in_ready", 64'(in_ready_a[0]), 64'd1);
    checkOutput("reset out_valid", 64'(out_valid_a[0]), 64'd0);
    checkOutput("reset spm_x", 64'(spm_x_a[0]), 64'd0);
    checkOutput("reset spm_y", 64'(spm_y_a[0]), 64'd0);
    checkOutput("reset prod", 64'(prod_a[0]), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < 6; v++) begin
        applyStimulus(d, vecs[v].a, vecs[v].b, vecs[v].p, vecs[v].stall, vecs[v].pre,
                      $sformatf("lane%0d vec%0d", d, v));
      end
    end

    // Reset while RUN is at k=7, then a clean operation afterwards.
    @(negedge clk);
    mc_a[0]       = 8'h55;
    mp_a[0]       = 8'hFF;
    in_valid_a[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midrun reset in_ready", 64'(in_ready_a[0]), 64'd1);
    checkOutput("midrun reset out_valid", 64'(out_valid_a[0]), 64'd0);
    checkOutput("midrun reset spm_x", 64'(spm_x_a[0]), 64'd0);
    checkOutput("midrun reset spm_y", 64'(spm_y_a[0]), 64'd0);
    checkOutput("midrun reset prod", 64'(prod_a[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 8'h02, 8'h09, 16'h0012, 0, 1'b0, "post reset");

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 500; n++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        re = $signed(ra) * $signed(rb);
        applyStimulus(d, ra, rb, re, int'($urandom_range(0, 3)), 1'($urandom),
                      $sformatf("lane%0d rand%0d", d, n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
